// File: rtl/int_div_pkg.sv
// Shared encodings, FSM state type and constants for the integer divide controller.
package int_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_FIX,
    ST_RESP,
    ST_DRAIN
  } div_state_e;

  localparam int          DIV_LATENCY = 34;
  localparam int          CNT_W       = 6;
  localparam logic [31:0] ALL_ONES    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  // Bit 0 clear selects the signed flavour, bit 1 set selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/int_div_sign_fix.sv
// Conditional two's-complement negate; doubles as absolute value when negate = sign bit.
module int_div_sign_fix (
  input  logic [31:0] value,
  input  logic        negate,
  output logic [31:0] result
);

  assign result = negate ? (~value + 32'd1) : value;

endmodule

// File: rtl/int_div_ctrl.sv
// Sequencing wrapper around an external unsigned 32-bit divider (sign prep, special cases, fix-up).
// Optional last-result cache is enabled by defining DIV_OPERAND_CACHE_EN.
module int_div_ctrl
  import int_div_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [31:0]       req_rs1_i,
  input  logic [31:0]       req_rs2_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_result_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  input  logic              flush_i,
  output logic              div_load_o,
  output logic [31:0]       div_dividend_o,
  output logic [31:0]       div_divisor_o,
  output logic              div_signed_o,
  input  logic [31:0]       div_quotient_i,
  input  logic [31:0]       div_remainder_i
);

  div_state_e        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              div_load_reg;
  logic [31:0]       result_reg;
  logic [TAG_W-1:0]  resp_tag_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [31:0]       dividend_reg;
  logic [31:0]       divisor_reg;
  logic              rem_sel_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;

  logic              req_signed;
  logic              accept;
  logic              div_zero;
  logic              overflow;
  logic [31:0]       special_result;
  logic              cache_hit;
  logic [31:0]       cache_result;
  logic [31:0]       q_fixed;
  logic [31:0]       r_fixed;
  logic [31:0]       op_raw [2];
  logic [31:0]       op_mag [2];

  assign req_signed = op_is_signed(req_op_i);
  assign accept     = req_valid_i & req_ready_reg & ~flush_i;
  assign div_zero   = (req_rs2_i == 32'd0);
  assign overflow   = req_signed && (req_rs1_i == INT_MIN) && (req_rs2_i == ALL_ONES);

  always_comb begin
    special_result = 32'd0;
    if (div_zero) begin
      special_result = op_is_rem(req_op_i) ? req_rs1_i : ALL_ONES;
    end else if (overflow) begin
      special_result = op_is_rem(req_op_i) ? 32'd0 : INT_MIN;
    end
  end

  assign op_raw[0] = req_rs1_i;
  assign op_raw[1] = req_rs2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      int_div_sign_fix u_abs (
        .value  (op_raw[gi]),
        .negate (req_signed & op_raw[gi][31]),
        .result (op_mag[gi])
      );
    end
  endgenerate

  int_div_sign_fix u_fix_q (
    .value  (div_quotient_i),
    .negate (q_neg_reg),
    .result (q_fixed)
  );

  int_div_sign_fix u_fix_r (
    .value  (div_remainder_i),
    .negate (r_neg_reg),
    .result (r_fixed)
  );

`ifdef DIV_OPERAND_CACHE_EN
  logic        cache_valid_reg;
  logic [31:0] cache_rs1_reg;
  logic [31:0] cache_rs2_reg;
  logic        cache_signed_reg;
  logic [31:0] cache_q_reg;
  logic [31:0] cache_r_reg;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic        signed_reg;

  assign cache_hit = cache_valid_reg && (cache_rs1_reg == req_rs1_i) &&
                     (cache_rs2_reg == req_rs2_i) && (cache_signed_reg == req_signed);
  assign cache_result = op_is_rem(req_op_i) ? cache_r_reg : cache_q_reg;

  // Only a completed divider run refreshes the cache; a flush in FIX leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_valid_reg  <= 1'b0;
      cache_rs1_reg    <= 32'd0;
      cache_rs2_reg    <= 32'd0;
      cache_signed_reg <= 1'b0;
      cache_q_reg      <= 32'd0;
      cache_r_reg      <= 32'd0;
      rs1_reg          <= 32'd0;
      rs2_reg          <= 32'd0;
      signed_reg       <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && accept) begin
        rs1_reg    <= req_rs1_i;
        rs2_reg    <= req_rs2_i;
        signed_reg <= req_signed;
      end
      if (state_reg == ST_FIX && !flush_i) begin
        cache_valid_reg  <= 1'b1;
        cache_rs1_reg    <= rs1_reg;
        cache_rs2_reg    <= rs2_reg;
        cache_signed_reg <= signed_reg;
        cache_q_reg      <= q_fixed;
        cache_r_reg      <= r_fixed;
      end
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = 32'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_DRAIN;
      cnt_reg        <= CNT_W'(DIV_LATENCY);
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      div_load_reg   <= 1'b0;
      result_reg     <= 32'd0;
      resp_tag_reg   <= '0;
      tag_reg        <= '0;
      dividend_reg   <= 32'd0;
      divisor_reg    <= 32'd0;
      rem_sel_reg    <= 1'b0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
    end else begin
      // Free-running countdown of cycles since the last divider start.
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_ready_reg <= 1'b0;
            if (div_zero || overflow) begin
              result_reg     <= special_result;
              resp_tag_reg   <= req_tag_i;
              resp_valid_reg <= 1'b1;
              state_reg      <= ST_RESP;
            end else if (cache_hit) begin
              result_reg     <= cache_result;
              resp_tag_reg   <= req_tag_i;
              resp_valid_reg <= 1'b1;
              state_reg      <= ST_RESP;
            end else begin
              dividend_reg <= op_mag[0];
              divisor_reg  <= op_mag[1];
              div_load_reg <= 1'b1;
              tag_reg      <= req_tag_i;
              rem_sel_reg  <= op_is_rem(req_op_i);
              q_neg_reg    <= req_signed & (req_rs1_i[31] ^ req_rs2_i[31]);
              r_neg_reg    <= req_signed & req_rs1_i[31];
              state_reg    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          div_load_reg <= 1'b0;
          cnt_reg      <= CNT_W'(DIV_LATENCY);
          state_reg    <= flush_i ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_i) begin
            state_reg <= ST_DRAIN;
          end else if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (flush_i) begin
            state_reg <= ST_DRAIN;
          end else begin
            result_reg     <= rem_sel_reg ? r_fixed : q_fixed;
            resp_tag_reg   <= tag_reg;
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // The divider cannot be reset or aborted, so wait out its latency.
          if (cnt_reg <= CNT_W'(1)) begin
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_DRAIN;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_reg;
  assign resp_valid_o   = resp_valid_reg;
  assign resp_result_o  = result_reg;
  assign resp_tag_o     = resp_tag_reg;
  assign div_load_o     = div_load_reg;
  assign div_dividend_o = dividend_reg;
  assign div_divisor_o  = divisor_reg;
  assign div_signed_o   = 1'b0;

endmodule

// File: doc/int_div_ctrl.md
INT_DIV_CTRL -- requirements
Module: int_div_ctrl

Interface
REQ-001 Parameter TAG_W, default 5, width of the destination-register tag carried with each request.
REQ-002 The block SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-003 clk_i  input  1  clock; all block state updates on posedge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 req_valid_i  input  1  divide request present.
REQ-006 req_ready_o  output  1  request accepted when req_valid_i and req_ready_o are both high at posedge.
REQ-007 req_op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 req_rs1_i  input  32  dividend.
REQ-009 req_rs2_i  input  32  divisor.
REQ-010 req_tag_i  input  TAG_W  request tag.
REQ-011 resp_valid_o  output  1  result available.
REQ-012 resp_ready_i  input  1  consumer takes result.
REQ-013 resp_result_o  output  32  quotient or remainder.
REQ-014 resp_tag_o  output  TAG_W  tag of the returned result.
REQ-015 flush_i  input  1  cancel in-flight request and any pending response.
REQ-016 div_load_o  output  1  start pulse to int_div_32.
REQ-017 div_dividend_o / div_divisor_o  output  32 each  operand magnitudes to the divider.
REQ-018 div_signed_o  output  1  divider signed mode; tied to 0.
REQ-019 div_quotient_i / div_remainder_i  input  32 each  unsigned divider results.

Function
REQ-020 States SHALL be IDLE, LOAD, WAIT, FIX, RESP and DRAIN; req_ready_o SHALL be high only in IDLE.
REQ-021 On accept, the block SHALL register op, operands, tag, sign of rs1 and sign of quotient (rs1[31]^rs2[31], signed ops only), and SHALL drive operand magnitudes (two's-complement absolute value for signed ops).
REQ-022 Special cases SHALL bypass the divider and go IDLE->RESP: rs2=0 gives quotient 0xFFFFFFFF and remainder rs1; signed rs1=0x80000000 with rs2=0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
REQ-023 Normal path: LOAD lasts 1 cycle with div_load_o=1; WAIT lasts DIV_LATENCY=34 cycles; FIX lasts 1 cycle and registers the signed results; resp_valid_o rises 36 cycles after the accept edge.
REQ-024 FIX SHALL negate the quotient when the quotient sign is 1, and SHALL negate the remainder when the signed op's rs1 is negative (remainder takes the dividend's sign).
REQ-025 In RESP, resp_valid_o, resp_result_o and resp_tag_o SHALL hold stable until resp_ready_i; the state goes to IDLE on the handshake edge, and a new request is accepted no earlier than the next edge.
REQ-026 flush_i in LOAD, WAIT or FIX SHALL enter DRAIN, and DRAIN SHALL hold req_ready_o low until 34 cycles have elapsed since the last div_load_o.
REQ-027 flush_i in RESP SHALL drop the response, with the state going to IDLE on the next cycle.
REQ-028 flush_i in IDLE SHALL be ignored, and flush_i SHALL take priority over an accept in the same cycle.

Reset
REQ-029 On reset: resp_valid_o=0, req_ready_o=0, div_load_o=0, resp_result_o=0, resp_tag_o=0; the state goes to DRAIN for 34 cycles (the divider has no reset) and then to IDLE.

Configuration
REQ-030 With DIV_OPERAND_CACHE_EN defined, the block SHALL keep the last completed non-special rs1, rs2, signedness, signed quotient and signed remainder plus a valid bit.
REQ-031 With DIV_OPERAND_CACHE_EN defined, the cache SHALL behave as follows:
- A matching request goes IDLE->RESP with no divider run.
- The cache is written in FIX.
- A flushed operation does not write the cache.
- Reset clears the valid bit.
- Without the macro, every non-special request takes the 36-cycle path.

Structure
REQ-032 Package int_div_pkg SHALL hold the op encoding, the state typedef, DIV_LATENCY, and the constants 0xFFFFFFFF and 0x80000000.
REQ-033 Sub-module int_div_sign_fix (combinational absolute value and conditional negate) SHALL be used for both operand prep and FIX; int_div_32 SHALL be instantiated by the parent.

Verification
REQ-034 DIVU 100/7 -> 14 at accept+36; REMU 100/7 -> 2.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
REQ-036 DIV 0x12345678/0 -> 0xFFFFFFFF at accept+1; REM -> 0x12345678; div_load_o never high.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both at accept+1.
REQ-038 flush_i on WAIT cycle 10 -> no response; req_ready_o stays low until 34 cycles after load; the next DIVU 9/3 -> 3.
REQ-039 DIV 1000/33 then REM 1000/33 -> REM 10 at accept+1 with DIV_OPERAND_CACHE_EN, at accept+36 without; with resp_ready_i low for 5 cycles, result and tag stay stable.
